// File: rtl/core_sequencer.sv
// Multi-cycle controller for the RV64 datapath: boot, fetch, decode, execute, memory, writeback.
// Optional performance counters are enabled with the SEQ_PERF_CNT_EN macro.
module core_sequencer #(
    parameter int FPU_LATENCY = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        in_start,
    input  logic [6:0]  in_opcode,
    input  logic        in_int_rf_we,
    input  logic        in_fp_rf_we,
    input  logic        in_imem_ack,
    input  logic        in_dmem_ack,
    output logic        out_load_init_addr,
    output logic        out_pc_we,
    output logic        out_ir_we,
    output logic        out_imem_req,
    output logic        out_dmem_req,
    output logic        out_dmem_we,
    output logic        out_int_rf_we,
    output logic        out_fp_rf_we,
    output logic        out_busy,
    output logic        out_halted,
    output logic        out_err,
    output logic [2:0]  out_state,
    output logic [63:0] out_cycle_cnt,
    output logic [63:0] out_instret
);

    localparam int EW = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BOOT   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        C_SIMPLE = 2'd0,
        C_LOAD   = 2'd1,
        C_STORE  = 2'd2,
        C_FP     = 2'd3
    } cls_t;

    state_t                 r_state, w_next;
    cls_t                   r_cls, w_cls;
    logic [EW-1:0]          r_exec_cnt;
    logic [TIMEOUT_W-1:0]   r_to_cnt;
    logic                   r_err;
    logic                   w_set_err;
    logic                   w_to_hit;
    logic                   w_waiting;
    logic                   w_is_system;

    always_comb begin
        w_cls = C_SIMPLE;
        case (in_opcode)
            7'b0000011, 7'b0000111: w_cls = C_LOAD;
            7'b0100011, 7'b0100111: w_cls = C_STORE;
            7'b1010011:             w_cls = C_FP;
            default:                w_cls = C_SIMPLE;
        endcase
    end

    assign w_is_system = (in_opcode == 7'b1110011);
    assign w_to_hit    = (r_to_cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));
    assign w_waiting   = ((r_state == S_FETCH) && !in_imem_ack) ||
                         ((r_state == S_MEM)   && !in_dmem_ack);

    // An ack is checked before the timeout so it wins when both land together.
    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE:   if (in_start) w_next = S_BOOT;
            S_BOOT:   w_next = S_FETCH;
            S_FETCH: begin
                if (in_imem_ack) begin
                    w_next = S_DECODE;
                end else if (w_to_hit) begin
                    w_next    = S_HALT;
                    w_set_err = 1'b1;
                end
            end
            S_DECODE: w_next = w_is_system ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (r_exec_cnt == '0)
                    w_next = ((r_cls == C_LOAD) || (r_cls == C_STORE)) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (in_dmem_ack) begin
                    w_next = S_WB;
                end else if (w_to_hit) begin
                    w_next    = S_HALT;
                    w_set_err = 1'b1;
                end
            end
            S_WB:     w_next = S_FETCH;
            S_HALT:   if (in_start) w_next = S_BOOT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_cls      <= C_SIMPLE;
            r_exec_cnt <= '0;
            r_to_cnt   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_err)
                r_err <= 1'b1;
            if (r_state == S_DECODE) begin
                r_cls      <= w_cls;
                r_exec_cnt <= (w_cls == C_FP) ? EW'(FPU_LATENCY - 1) : '0;
            end else if ((r_state == S_EXEC) && (r_exec_cnt != '0)) begin
                r_exec_cnt <= r_exec_cnt - 1'b1;
            end
            // Counter only runs while a request is outstanding, so it restarts on each entry.
            if (w_waiting)
                r_to_cnt <= r_to_cnt + 1'b1;
            else
                r_to_cnt <= '0;
        end
    end

    assign out_load_init_addr = (r_state == S_BOOT);
    assign out_pc_we          = (r_state == S_BOOT) || (r_state == S_WB);
    assign out_ir_we          = (r_state == S_FETCH) && in_imem_ack;
    assign out_imem_req       = (r_state == S_FETCH);
    assign out_dmem_req       = (r_state == S_MEM);
    assign out_dmem_we        = (r_state == S_MEM) && (r_cls == C_STORE);
    assign out_int_rf_we      = (r_state == S_WB) && (r_cls != C_STORE) && in_int_rf_we;
    assign out_fp_rf_we       = (r_state == S_WB) && (r_cls != C_STORE) && in_fp_rf_we;
    assign out_busy           = (r_state != S_IDLE) && (r_state != S_HALT);
    assign out_halted         = (r_state == S_HALT);
    assign out_err            = r_err;
    assign out_state          = r_state;

`ifdef SEQ_PERF_CNT_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cycle_cnt <= '0;
            r_instret   <= '0;
        end else begin
            if (out_busy)
                r_cycle_cnt <= r_cycle_cnt + 64'd1;
            if (r_state == S_WB)
                r_instret <= r_instret + 64'd1;
        end
    end

    assign out_cycle_cnt = r_cycle_cnt;
    assign out_instret   = r_instret;
`else
    assign out_cycle_cnt = '0;
    assign out_instret   = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: per-cycle expected output vectors are queued with the stimulus
// and compared against the DUT on the falling edge.
module tb_core_sequencer;

    localparam int FPU_LAT = 4;
    localparam int MEM_TO  = 10;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_BOOT = 3'd1, ST_FETCH = 3'd2, ST_DECODE = 3'd3,
                           ST_EXEC = 3'd4, ST_MEM = 3'd5, ST_WB = 3'd6, ST_HALT = 3'd7;

    // Flag order: load_init, pc_we, ir_we, imem_req, dmem_req, dmem_we, int_rf_we, fp_rf_we
    localparam logic [7:0] F_NONE = 8'b0000_0000;
    localparam logic [7:0] F_BOOT = 8'b1100_0000;
    localparam logic [7:0] F_IREQ = 8'b0001_0000;
    localparam logic [7:0] F_IACK = 8'b0011_0000;
    localparam logic [7:0] F_DREQ = 8'b0000_1000;
    localparam logic [7:0] F_DWE  = 8'b0000_0100;
    localparam logic [7:0] F_PCWE = 8'b0100_0000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_start = 1'b0;
    logic [6:0]  in_opcode = 7'd0;
    logic        in_int_rf_we = 1'b0;
    logic        in_fp_rf_we = 1'b0;
    logic        in_imem_ack = 1'b0;
    logic        in_dmem_ack = 1'b0;
    logic        out_load_init_addr, out_pc_we, out_ir_we, out_imem_req, out_dmem_req, out_dmem_we;
    logic        out_int_rf_we, out_fp_rf_we, out_busy, out_halted, out_err;
    logic [2:0]  out_state;
    logic [63:0] out_cycle_cnt, out_instret;

    core_sequencer #(.FPU_LATENCY(FPU_LAT), .MEM_TIMEOUT(MEM_TO), .TIMEOUT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .in_start(in_start), .in_opcode(in_opcode),
        .in_int_rf_we(in_int_rf_we), .in_fp_rf_we(in_fp_rf_we),
        .in_imem_ack(in_imem_ack), .in_dmem_ack(in_dmem_ack),
        .out_load_init_addr(out_load_init_addr), .out_pc_we(out_pc_we), .out_ir_we(out_ir_we),
        .out_imem_req(out_imem_req), .out_dmem_req(out_dmem_req), .out_dmem_we(out_dmem_we),
        .out_int_rf_we(out_int_rf_we), .out_fp_rf_we(out_fp_rf_we), .out_busy(out_busy),
        .out_halted(out_halted), .out_err(out_err), .out_state(out_state),
        .out_cycle_cnt(out_cycle_cnt), .out_instret(out_instret)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;
    logic        g_err = 1'b0;
    logic [63:0] exp_busy = 64'd0;
    logic [63:0] exp_ret = 64'd0;
    int          lat;

    wire logic [15:0] w_obs = {out_state, out_load_init_addr, out_pc_we, out_ir_we, out_imem_req,
                               out_dmem_req, out_dmem_we, out_int_rf_we, out_fp_rf_we,
                               out_busy, out_halted, out_err, 1'b0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("trace{state,ldi,pcwe,irwe,ireq,dreq,dwe,iwe,fwe,busy,halt,err}",
                  {48'd0, w_obs}, {48'd0, mon_e});
        end
    end

    // Queue one cycle of expected outputs, then advance to just after the next rising edge.
    task automatic cyc(input logic [2:0] st, input logic [7:0] f);
        logic busy;
        logic halt;
        busy = (st != ST_IDLE) && (st != ST_HALT);
        halt = (st == ST_HALT);
        exp_q.push_back({st, f, busy, halt, g_err, 1'b0});
        if (busy) exp_busy = exp_busy + 64'd1;
        if (st == ST_WB) exp_ret = exp_ret + 64'd1;
        @(posedge Clk);
        #1;
    endtask

    // Starts in FETCH; noise raises start and both acks where they must be ignored.
    task automatic run_instr(input logic [6:0] op, input int id, input int dd,
                             input logic iwe, input logic fwe, input logic noise, output int n);
        logic ld, st, fp, sys;
        n  = 0;
        ld = (op == 7'b0000011) || (op == 7'b0000111);
        st = (op == 7'b0100011) || (op == 7'b0100111);
        fp = (op == 7'b1010011);
        sys = (op == 7'b1110011);
        in_opcode = op; in_int_rf_we = iwe; in_fp_rf_we = fwe;
        in_start = noise; in_dmem_ack = noise;
        for (int i = 0; i < id; i++) begin
            in_imem_ack = 1'b0; cyc(ST_FETCH, F_IREQ); n++;
        end
        in_imem_ack = 1'b1; cyc(ST_FETCH, F_IACK); n++;
        in_imem_ack = noise;
        cyc(ST_DECODE, F_NONE); n++;
        if (!sys) begin
            for (int i = 0; i < (fp ? FPU_LAT : 1); i++) begin
                cyc(ST_EXEC, F_NONE); n++;
            end
            if (ld || st) begin
                in_dmem_ack = 1'b0;
                for (int i = 0; i < dd; i++) begin
                    cyc(ST_MEM, F_DREQ | (st ? F_DWE : F_NONE)); n++;
                end
                in_dmem_ack = 1'b1;
                cyc(ST_MEM, F_DREQ | (st ? F_DWE : F_NONE)); n++;
                in_dmem_ack = 1'b0;
            end
            cyc(ST_WB, F_PCWE | {6'd0, iwe & ~st, fwe & ~st}); n++;
        end
        in_start = 1'b0; in_imem_ack = 1'b0; in_dmem_ack = 1'b0;
        in_int_rf_we = 1'b0; in_fp_rf_we = 1'b0;
    endtask

    task automatic check_perf(input string tag);
`ifdef SEQ_PERF_CNT_EN
        check({tag, "_cycle_cnt"}, out_cycle_cnt, exp_busy);
        check({tag, "_instret"}, out_instret, exp_ret);
`else
        check({tag, "_cycle_cnt_tied"}, out_cycle_cnt, 64'd0);
        check({tag, "_instret_tied"}, out_instret, 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        cyc(ST_IDLE, F_NONE);
        Rst = 1'b0; exp_busy = 64'd0; exp_ret = 64'd0;
        check_perf("reset");

        // Boot then two simple instructions (second with ignored start/ack noise)
        in_start = 1'b1; cyc(ST_IDLE, F_NONE);
        in_start = 1'b0; cyc(ST_BOOT, F_BOOT);
        run_instr(7'b0110011, 0, 0, 1'b1, 1'b0, 1'b0, lat);
        check("lat_simple", 64'(lat), 64'd4);
        run_instr(7'b0010011, 0, 0, 1'b1, 1'b1, 1'b1, lat);
        check("lat_simple_noise", 64'(lat), 64'd4);
        check_perf("two_simple");
`ifdef SEQ_PERF_CNT_EN
        check("instret_two_simple", out_instret, 64'd2);
`endif

        run_instr(7'b0000011, 0, 3, 1'b1, 1'b0, 1'b0, lat);
        check("lat_load_dmem_dly3", 64'(lat), 64'd8);
        run_instr(7'b0100011, 0, 0, 1'b1, 1'b0, 1'b0, lat);
        check("lat_store", 64'(lat), 64'd5);
        run_instr(7'b1010011, 0, 0, 1'b0, 1'b1, 1'b0, lat);
        check("lat_opfp", 64'(lat), 64'd7);
        // Acks landing on the last permitted waiting cycle must win over the timeout
        run_instr(7'b0000111, MEM_TO - 1, 0, 1'b0, 1'b1, 1'b0, lat);
        check("lat_loadfp_imem_edge", 64'(lat), 64'd14);
        run_instr(7'b0100111, 0, MEM_TO - 1, 1'b0, 1'b1, 1'b0, lat);
        check("lat_storefp_dmem_edge", 64'(lat), 64'd14);
        check("no_err_at_edge", {63'd0, out_err}, 64'd0);
        check_perf("after_mix");

        // Instruction memory never answers
        in_imem_ack = 1'b0;
        for (int i = 0; i < MEM_TO; i++) cyc(ST_FETCH, F_IREQ);
        g_err = 1'b1;
        in_start = 1'b1; cyc(ST_HALT, F_NONE);
        in_start = 1'b0; cyc(ST_BOOT, F_BOOT);
        check("err_sticky_after_restart", {63'd0, out_err}, 64'd1);

        run_instr(7'b1110011, 0, 0, 1'b1, 1'b0, 1'b0, lat);
        check("lat_system", 64'(lat), 64'd2);
        cyc(ST_HALT, F_NONE);
        in_start = 1'b1; cyc(ST_HALT, F_NONE);
        in_start = 1'b0; cyc(ST_BOOT, F_BOOT);

        // Reset while a load waits in MEM
        in_opcode = 7'b0000011; in_int_rf_we = 1'b1;
        in_imem_ack = 1'b1; cyc(ST_FETCH, F_IACK);
        in_imem_ack = 1'b0; cyc(ST_DECODE, F_NONE);
        cyc(ST_EXEC, F_NONE);
        cyc(ST_MEM, F_DREQ);
        cyc(ST_MEM, F_DREQ);
        Rst = 1'b1; cyc(ST_MEM, F_DREQ);
        Rst = 1'b0; g_err = 1'b0; exp_busy = 64'd0; exp_ret = 64'd0;
        cyc(ST_IDLE, F_NONE);
        cyc(ST_IDLE, F_NONE);
        check_perf("after_mid_reset");
        in_int_rf_we = 1'b0;

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
